mc_alu: RTL and testbench

MC_ALU -- requirements
Module: mc_alu

---
 rtl/mc_alu.sv | 199 +++++++++++++++++++
 tb/tb_mc_alu.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle add/sub/logic ops, shift-add multiply, restoring divide.
// Divider is built only when MC_ALU_DIV_EN is defined; otherwise DIV completes at once with 0.
module mc_alu #(
  parameter int unsigned WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             div0,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpMul = 4'b0010;
  localparam logic [3:0] OpDiv = 4'b0011;
  localparam logic [3:0] OpAnd = 4'b0100;
  localparam logic [3:0] OpOr  = 4'b0101;
  localparam logic [3:0] OpXor = 4'b0110;
  localparam logic [3:0] OpInc = 4'b1000;
  localparam logic [3:0] OpDec = 4'b1001;
  localparam logic [3:0] OpNot = 4'b1010;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;       // multiplicand or divisor
  logic [2*WIDTH-1:0] work_q, work_d;       // {acc/remainder, multiplier/quotient}
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               div0_q, div0_d;
  logic               done_q, done_d;

  logic               last_iter;
  logic [WIDTH:0]     add_full, sub_full, mul_sum;
  logic [WIDTH-1:0]   single_res;
  logic               single_carry;
  logic [2*WIDTH-1:0] mul_next;

  assign last_iter = (cnt_q == CntW'(WIDTH - 1));
  assign add_full  = {1'b0, a} + {1'b0, b};
  assign sub_full  = {1'b0, a} - {1'b0, b};

  // Shift-add step: add multiplicand into the high half when the multiplier LSB is set.
  assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

`ifdef MC_ALU_DIV_EN
  logic [WIDTH:0]     rem_sh, rem_sub;
  logic [2*WIDTH-1:0] div_next;

  // Restoring step: remainder never exceeds the divisor, so W+1 bits hold the trial subtract.
  assign rem_sh   = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
  assign rem_sub  = rem_sh - {1'b0, opnd_q};
  assign div_next = rem_sub[WIDTH] ? {rem_sh[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                                   : {rem_sub[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
`endif

  always_comb begin
    single_res   = '0;
    single_carry = 1'b0;
    case (op)
      OpAdd: begin single_res = add_full[WIDTH-1:0]; single_carry = add_full[WIDTH]; end
      OpSub: begin single_res = sub_full[WIDTH-1:0]; single_carry = sub_full[WIDTH]; end
      OpAnd: single_res = a & b;
      OpOr:  single_res = a | b;
      OpXor: single_res = a ^ b;
      OpInc: begin single_res = a + 1'b1; single_carry = &a; end
      OpDec: begin single_res = a - 1'b1; single_carry = ~|a; end
      OpNot: single_res = ~a;
      OpDiv: single_res = '0;
      default: single_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op == OpMul) state_d = StMul;
`ifdef MC_ALU_DIV_EN
          else if (op == OpDiv && b != '0) state_d = StDiv;
`endif
        end
      end
      StMul, StDiv: if (last_iter) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != StIdle);
  end

  always_comb begin
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    work_d   = work_q;
    result_d = result_q;
    carry_d  = carry_q;
    div0_d   = div0_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d = '0;
          if (op == OpMul) begin
            opnd_d = a;
            work_d = {{WIDTH{1'b0}}, b};
`ifdef MC_ALU_DIV_EN
          end else if (op == OpDiv && b == '0) begin
            result_d = '1;
            carry_d  = 1'b0;
            div0_d   = 1'b1;
            done_d   = 1'b1;
          end else if (op == OpDiv) begin
            opnd_d = b;
            work_d = {{WIDTH{1'b0}}, a};
`endif
          end else begin
            result_d = single_res;
            carry_d  = single_carry;
            div0_d   = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
      StMul: begin
        work_d = mul_next;
        cnt_d  = cnt_q + CntW'(1);
        if (last_iter) begin
          result_d = mul_next[WIDTH-1:0];
          carry_d  = |mul_next[2*WIDTH-1:WIDTH];
          div0_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      StDiv: begin
`ifdef MC_ALU_DIV_EN
        work_d = div_next;
        cnt_d  = cnt_q + CntW'(1);
        if (last_iter) begin
          result_d = div_next[WIDTH-1:0];
          carry_d  = 1'b0;
          div0_d   = 1'b0;
          done_d   = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      opnd_q   <= '0;
      work_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      work_q   <= work_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign zero   = (result_q == '0);
  assign carry  = carry_q;
  assign div0   = div0_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mc_alu.sv
// Directed self-checking bench for mc_alu at WIDTH=19; DIV checks follow MC_ALU_DIV_EN.
module tb_mc_alu;

  localparam int unsigned W = 19;

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpMul = 4'b0010;
  localparam logic [3:0] OpDiv = 4'b0011;
  localparam logic [3:0] OpAnd = 4'b0100;
  localparam logic [3:0] OpOr  = 4'b0101;
  localparam logic [3:0] OpXor = 4'b0110;
  localparam logic [3:0] OpInc = 4'b1000;
  localparam logic [3:0] OpDec = 4'b1001;
  localparam logic [3:0] OpNot = 4'b1010;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] result;
  logic         zero, carry, div0, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  mc_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .zero   (zero),
    .carry  (carry),
    .div0   (div0),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one start pulse, then wait (bounded) for done; lat counts cycles after the start edge.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output int nbusy);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (!done && lat < 60) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic single(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp_res, input logic exp_c);
    int lat, nb;
    run_op(o, x, y, lat, nb);
    check_eq({tag, "_lat"}, lat, 1);
    check_eq({tag, "_res"}, result, exp_res);
    check_eq({tag, "_carry"}, carry, exp_c);
  endtask

  initial begin
    int lat, nb, ndone;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_result", result, 0);
    check_eq("rst_zero", zero, 1);
    check_eq("rst_carry", carry, 0);
    check_eq("rst_div0", div0, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    rst = 1'b0;

    run_op(OpAdd, 19'h7FFFF, 19'h00001, lat, nb);
    check_eq("add_lat", lat, 1);
    check_eq("add_done", done, 1);
    check_eq("add_res", result, 0);
    check_eq("add_carry", carry, 1);
    check_eq("add_zero", zero, 1);

    single("sub", OpSub, 19'd3, 19'd5, 19'h7FFFE, 1'b1);
    check_eq("sub_zero", zero, 0);
    single("and", OpAnd, 19'h0F0F0, 19'h0FF00, 19'h0F000, 1'b0);
    single("or",  OpOr,  19'h0F0F0, 19'h0FF00, 19'h0FFF0, 1'b0);
    single("xor", OpXor, 19'h0F0F0, 19'h0FF00, 19'h00FF0, 1'b0);
    single("inc", OpInc, 19'h7FFFF, 19'd9,     19'h00000, 1'b1);
    single("dec", OpDec, 19'h00000, 19'd9,     19'h7FFFF, 1'b1);
    single("not", OpNot, 19'h12345, 19'd0,     19'h6DCBA, 1'b0);
    single("badop", 4'b0111, 19'd5, 19'd3,     19'h00000, 1'b0);

    run_op(OpMul, 19'd300, 19'd500, lat, nb);
    check_eq("mul_busy", nb, W);
    check_eq("mul_lat", lat, W + 1);
    check_eq("mul_busy_fall", busy, 0);
    check_eq("mul_res", result, 150000);
    check_eq("mul_carry", carry, 0);
    repeat (3) @(negedge clk);
    check_eq("hold_res", result, 150000);
    check_eq("hold_done", done, 0);

    run_op(OpMul, 19'h40000, 19'd2, lat, nb);
    check_eq("mulov_res", result, 0);
    check_eq("mulov_carry", carry, 1);
    check_eq("mulov_zero", zero, 1);

`ifdef MC_ALU_DIV_EN
    run_op(OpDiv, 19'd100000, 19'd7, lat, nb);
    check_eq("div_busy", nb, W);
    check_eq("div_lat", lat, W + 1);
    check_eq("div_res", result, 14285);
    check_eq("div_div0", div0, 0);
    run_op(OpDiv, 19'd1234, 19'd0, lat, nb);
    check_eq("div0_lat", lat, 1);
    check_eq("div0_busy", nb, 0);
    check_eq("div0_res", result, 19'h7FFFF);
    check_eq("div0_flag", div0, 1);
    single("div0_clr", OpAdd, 19'd2, 19'd2, 19'd4, 1'b0);
    check_eq("div0_cleared", div0, 0);
`else
    run_op(OpDiv, 19'd100, 19'd5, lat, nb);
    check_eq("nodiv_lat", lat, 1);
    check_eq("nodiv_busy", nb, 0);
    check_eq("nodiv_res", result, 0);
    check_eq("nodiv_div0", div0, 0);
    check_eq("nodiv_carry", carry, 0);
`endif

    // Start during MUL must be ignored; a start in the done cycle must be taken.
    @(negedge clk);
    op = OpMul; a = 19'd300; b = 19'd500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    ndone = 0;
    while (!done && lat < 60) begin
      if (lat == 5) begin
        op = OpAdd; a = 19'd1; b = 19'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    check_eq("ign_lat", lat, W + 1);
    check_eq("ign_res", result, 150000);
    op = OpAdd; a = 19'd1; b = 19'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("b2b_done", done, 1);
    check_eq("b2b_res", result, 3);
    for (int i = 0; i < 4; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check_eq("b2b_single_pulse", ndone, 1);

    // Reset mid-operation, then a clean SUB.
    @(negedge clk);
`ifdef MC_ALU_DIV_EN
    op = OpDiv;
`else
    op = OpMul;
`endif
    a = 19'd100000; b = 19'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_res", result, 0);
    check_eq("mid_rst_zero", zero, 1);
    check_eq("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    single("post_rst_sub", OpSub, 19'd3, 19'd5, 19'h7FFFE, 1'b1);
    check_eq("post_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
